return_addr_stack: RTL
======================

RETURN_ADDR_STACK -- requirements
Module: return_addr_stack

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the number of entries; it SHALL be a power of two and at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port stall, input, 1 bit: pipeline freeze; when 1, push and pop are ignored.
REQ-005 The block SHALL have port push, input, 1 bit: a jal is in decode; store its return address.
REQ-006 The block SHALL have port push_addr, input, 32 bits: the return address to store.
REQ-007 The block SHALL have port pop, input, 1 bit: a jr $ra is in decode; predict its target.
REQ-008 The block SHALL have port pred_valid, output, 1 bit, registered: pred_addr holds a valid prediction this cycle.
REQ-009 The block SHALL have port pred_addr, output, 32 bits, registered: the predicted jr target.
REQ-010 The block SHALL have port count, output, $clog2(DEPTH)+1 bits, registered: the number of valid entries, 0..DEPTH.
REQ-011 The block SHALL have ports full and empty, output, 1 bit each: full is (count==DEPTH) and empty is (count==0), combinational from count.
REQ-012 The block SHALL have ports overflow and underflow, output, 1 bit each, registered: one-cycle event pulses.

Function
REQ-013 Storage SHALL be a DEPTH x 32 circular array with top pointer tp ($clog2(DEPTH) bits), indexed modulo DEPTH.
REQ-014 Push only, stall=0: the block SHALL set tp to tp+1 and write mem[tp+1] with push_addr; count SHALL increment, saturating at DEPTH.
REQ-015 Push when full: the oldest entry SHALL be silently overwritten (wrap-around), count SHALL stay at DEPTH, and overflow SHALL pulse 1 the next cycle.
REQ-016 Pop only, count>0, stall=0: the next cycle pred_valid SHALL be 1 and pred_addr SHALL equal mem[tp]; tp SHALL become tp-1 and count SHALL become count-1.
REQ-017 Pop when empty: the next cycle pred_valid SHALL be 0, underflow SHALL pulse 1, pred_addr SHALL hold its previous value, and tp and count SHALL be unchanged.
REQ-018 Push and pop together, count>0: pred_addr SHALL take the old mem[tp] and pred_valid SHALL be 1; mem[tp] SHALL become push_addr; tp and count SHALL be unchanged.
REQ-019 Push and pop together, count==0: the block SHALL behave as push only (REQ-014), and underflow SHALL pulse 1 with pred_valid 0.
REQ-020 pred_valid SHALL be 1 for exactly one cycle per successful pop; it SHALL be 0 in every cycle after a cycle with no successful pop.
REQ-021 With stall=1: push and pop SHALL be ignored, pred_valid, overflow and underflow SHALL be 0 the next cycle, and all other state SHALL hold.
REQ-022 Prediction latency SHALL be one cycle from the pop edge; no combinational path SHALL exist from push, pop or push_addr to any output.
REQ-023 An overflowed push followed by DEPTH pops SHALL return the DEPTH newest addresses in LIFO order; a further pop SHALL underflow.

Reset
REQ-024 On a clk edge with rst=1, the block SHALL set tp to DEPTH-1, count 0, pred_valid 0, pred_addr 0, overflow 0 and underflow 0, so empty=1 and full=0.
REQ-025 rst SHALL take priority over stall, push and pop in the same cycle.
REQ-026 Memory contents SHALL need no reset; reset mid-operation SHALL discard all entries, and a pop the cycle after reset SHALL underflow.

Verification
REQ-027 Push 0x00400010, then 0x00400020, then pop twice -> pred_addr 0x00400020 then 0x00400010, pred_valid 1 each cycle after a pop, count 2->1->0, empty=1.
REQ-028 DEPTH=8: push 0x100..0x900 in steps of 0x100 (9 pushes) -> overflow pulse on the 9th, count=8, full=1; 8 pops -> 0x900 down to 0x200; 9th pop -> underflow=1, pred_valid=0.
REQ-029 Push 0xA0, then push 0xB0 with pop in the same cycle -> pred_addr=0xA0, count stays 1; a subsequent pop -> pred_addr=0xB0.
REQ-030 With count=2, hold stall=1 while driving push and pop for 3 cycles -> count stays 2, pred_valid 0; release stall and pop -> top entry is unchanged.
REQ-031 Push 3 entries, assert rst together with pop -> count=0, pred_valid=0 the next cycle; pop the cycle after -> underflow=1.

Source files
------------

// File: rtl/return_addr_stack.sv
// Return address stack for jal/jr $ra target prediction.
// Circular DEPTH x 32 storage addressed by a top pointer; a push onto a full
// stack silently overwrites the oldest entry. Predictions are registered and
// appear one cycle after the pop edge.
module return_addr_stack #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     push,
    input  logic [31:0]              push_addr,
    input  logic                     pop,
    output logic                     pred_valid,
    output logic [31:0]              pred_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Operation selected for this cycle, resolved from stall/push/pop/count.
    typedef enum logic [2:0] {
        OP_IDLE,        // nothing to do (or stalled)
        OP_PUSH,        // push only
        OP_PUSH_UNDER,  // push and pop on an empty stack: acts as push, flags underflow
        OP_POP,         // pop with at least one valid entry
        OP_UNDER,       // pop on an empty stack
        OP_SWAP         // push and pop together with entries present
    } op_t;

    op_t            op;
    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  tp;
    logic [AW-1:0]  tp_inc;
    logic [AW-1:0]  tp_dec;

    assign tp_inc = tp + AW'(1);
    assign tp_dec = tp - AW'(1);
    assign full   = (count == FULL_COUNT);
    assign empty  = (count == '0);

    // Decode the requested operation; stall forces idle.
    always_comb begin
        op = OP_IDLE;
        if (!stall) begin
            if (push && pop) begin
                op = empty ? OP_PUSH_UNDER : OP_SWAP;
            end else if (push) begin
                op = OP_PUSH;
            end else if (pop) begin
                op = empty ? OP_UNDER : OP_POP;
            end
        end
    end

    // Pointer, occupancy, prediction and event-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tp         <= AW'(DEPTH - 1);
            count      <= '0;
            pred_valid <= 1'b0;
            pred_addr  <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            pred_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            case (op)
                OP_PUSH, OP_PUSH_UNDER: begin
                    tp <= tp_inc;
                    if (full) begin
                        overflow <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                    if (op == OP_PUSH_UNDER) begin
                        underflow <= 1'b1;
                    end
                end
                OP_POP: begin
                    pred_valid <= 1'b1;
                    pred_addr  <= mem[tp];
                    tp         <= tp_dec;
                    count      <= count - CW'(1);
                end
                OP_UNDER: begin
                    underflow <= 1'b1;
                end
                OP_SWAP: begin
                    pred_valid <= 1'b1;
                    pred_addr  <= mem[tp];
                end
                default: begin
                end
            endcase
        end
    end

    // Entry storage; no reset needed since count gates validity.
    always_ff @(posedge clk) begin
        if (!rst) begin
            case (op)
                OP_PUSH, OP_PUSH_UNDER: mem[tp_inc] <= push_addr;
                OP_SWAP:                mem[tp]     <= push_addr;
                default: begin
                end
            endcase
        end
    end

endmodule
